// File: rtl/key_pkg.sv
// Shared definitions for the PS/2 key writer: memory-op encodings,
// PS/2 prefix bytes, writer FSM states and the ring-pointer helper.
package key_pkg;

  localparam logic [2:0] MEMOP_SB  = 3'd0;
  localparam logic [2:0] MEMOP_SW  = 3'd2;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    WR_BYTE = 2'd2,
    WR_PTR  = 2'd3
  } wr_state_t;

  // Advance a ring pointer by one byte, wrapping from the last slot to the base.
  function automatic logic [7:0] ring_next(input logic [7:0] ptr,
                                           input logic [7:0] base,
                                           input logic [7:0] last);
    return (ptr == last) ? base : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_key_writer_if.sv
// Keyboard-memory write port: byte address, right-justified write data,
// memory operation and a one-cycle write strobe.
interface ps2_key_writer_if;
  logic [7:0]  waddr;
  logic [31:0] datain;
  logic [2:0]  memop;
  logic        we;

  modport master (output waddr, output datain, output memop, output we);
  modport slave  (input  waddr, input  datain, input  memop, input  we);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: three-flop synchronizers, falling-edge detect on
// ps2_clk, 11-bit shift (start, 8 data LSB first, odd parity, stop) and an
// inactivity timeout that discards a partial frame.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_vld,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic          ps2_data_p0, ps2_data_p1, ps2_data_p2;
  logic          fall;
  logic          bit_d;
  logic [9:0]    shreg;
  logic [3:0]    bitcnt;
  logic [TW-1:0] tocnt;

  // Frame is good when start is 0, stop is 1 and data+parity has odd weight.
  function automatic logic frame_ok(input logic [9:0] sr, input logic stop);
    return (sr[0] == 1'b0) && stop && (^sr[9:1] == 1'b1);
  endfunction

  // Synchronizer chains; idle level of both PS/2 lines is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
      ps2_data_p2 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
      ps2_data_p2 <= ps2_data_p1;
    end
  end

  assign fall  = ps2_clk_p2 & ~ps2_clk_p1;
  assign bit_d = ps2_data_p2;

  // Shift each sampled bit in from the top; after ten edges bit 0 sits at [0].
  always_ff @(posedge clk) begin
    if (fall) shreg <= {bit_d, shreg[9:1]};
  end

  // Bit counter, frame check on the 11th edge, and inactivity timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt  <= 4'd0;
      tocnt   <= '0;
      rx_byte <= 8'h00;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      rx_err <= 1'b0;
      if (fall) begin
        tocnt <= '0;
        if (bitcnt == 4'd10) begin
          bitcnt <= 4'd0;
          if (frame_ok(shreg, bit_d)) begin
            rx_byte <= shreg[8:1];
            rx_vld  <= 1'b1;
          end else begin
            rx_err  <= 1'b1;
          end
        end else begin
          bitcnt <= bitcnt + 4'd1;
        end
      end else if (bitcnt != 4'd0) begin
        if (tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
          tocnt  <= '0;
          bitcnt <= 4'd0;
          rx_err <= 1'b1;
        end else begin
          tocnt <= tocnt + 1'b1;
        end
      end else begin
        tocnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_writer.sv
// PS/2 keyboard producer: receives frames, filters scan codes and stores
// accepted bytes into a byte ring in keyboard memory, followed each time by
// a word store of the updated head pointer.
// Optional build macro KEY_BREAK_EN: when defined, break prefixes (F0) and
// the byte after them are stored as ordinary ring entries.
module ps2_key_writer
  import key_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] RING_BASE      = 8'h10,
  parameter logic [7:0] RING_LAST      = 8'hFF,
  parameter logic [7:0] PTR_ADDR       = 8'h00
) (
  input  logic                    wrclk,
  input  logic                    rst,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  ps2_key_writer_if.master        mem,
  output logic                    key_valid,
  output logic [7:0]              key_code,
  output logic                    frame_err
);

  logic [7:0]  rx_byte;
  logic        rx_vld;
  logic        rx_err;

  logic        hold_vld;
  logic [7:0]  hold_code;
  logic        hold_clr;
  logic        accept;

  wr_state_t   state, state_n;
  logic [7:0]  wptr, wptr_n;
  logic [7:0]  waddr_q, waddr_n;
  logic [31:0] datain_q, datain_n;
  logic [2:0]  memop_q, memop_n;
  logic        we_q, we_n;
  logic        kv_n;
  logic [7:0]  kc_n;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (wrclk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_vld   (rx_vld),
    .rx_err   (rx_err)
  );

  assign frame_err = rx_err;

  // Holding flag: a newly received byte wins over a same-cycle clear.
  always_ff @(posedge wrclk or posedge rst) begin
    if (rst)           hold_vld <= 1'b0;
    else if (rx_vld)   hold_vld <= 1'b1;
    else if (hold_clr) hold_vld <= 1'b0;
  end

  // Holding register payload; a late frame simply overwrites it.
  always_ff @(posedge wrclk) begin
    if (rx_vld) hold_code <= rx_byte;
  end

`ifdef KEY_BREAK_EN
  // Only the extended prefix is dropped; break codes are stored like keys.
  always_comb accept = (hold_code != PS2_EXT);
`else
  logic brk, brk_n;

  // Break filter: F0 arms brk, E0 is transparent, the byte after F0 is eaten.
  always_comb begin
    brk_n  = brk;
    accept = 1'b0;
    if (hold_code == PS2_BREAK) begin
      brk_n = 1'b1;
    end else if (hold_code == PS2_EXT) begin
      brk_n = brk;
    end else if (brk) begin
      brk_n = 1'b0;
    end else begin
      accept = 1'b1;
    end
  end

  // brk only moves when the FSM consumes a held byte.
  always_ff @(posedge wrclk or posedge rst) begin
    if (rst)                               brk <= 1'b0;
    else if ((state == IDLE) && hold_vld)  brk <= brk_n;
  end
`endif

  // Writer FSM next-state and next registered outputs.
  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    waddr_n  = waddr_q;
    datain_n = datain_q;
    memop_n  = memop_q;
    we_n     = 1'b0;
    kv_n     = 1'b0;
    kc_n     = key_code;
    hold_clr = 1'b0;
    unique case (state)
      INIT: begin
        we_n     = 1'b1;
        waddr_n  = PTR_ADDR;
        datain_n = {24'b0, wptr};
        memop_n  = MEMOP_SW;
        state_n  = IDLE;
      end
      IDLE: begin
        if (hold_vld) begin
          if (accept) begin
            kv_n    = 1'b1;
            kc_n    = hold_code;
            state_n = WR_BYTE;
          end else begin
            hold_clr = 1'b1;
          end
        end
      end
      WR_BYTE: begin
        we_n     = 1'b1;
        waddr_n  = wptr;
        datain_n = {24'b0, key_code};
        memop_n  = MEMOP_SB;
        wptr_n   = ring_next(wptr, RING_BASE, RING_LAST);
        state_n  = WR_PTR;
      end
      WR_PTR: begin
        we_n     = 1'b1;
        waddr_n  = PTR_ADDR;
        datain_n = {24'b0, wptr};
        memop_n  = MEMOP_SW;
        hold_clr = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  // Writer FSM state, head pointer and registered memory/status outputs.
  always_ff @(posedge wrclk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      wptr      <= RING_BASE;
      waddr_q   <= 8'h00;
      datain_q  <= 32'h0;
      memop_q   <= MEMOP_SW;
      we_q      <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 8'h00;
    end else begin
      state     <= state_n;
      wptr      <= wptr_n;
      waddr_q   <= waddr_n;
      datain_q  <= datain_n;
      memop_q   <= memop_n;
      we_q      <= we_n;
      key_valid <= kv_n;
      key_code  <= kc_n;
    end
  end

  assign mem.waddr  = waddr_q;
  assign mem.datain = datain_q;
  assign mem.memop  = memop_q;
  assign mem.we     = we_q;

endmodule

// File: tb/tb_ps2_key_writer.sv
// Directed bench for ps2_key_writer: PS/2 frames are bit-banged, memory
// stores are captured into a queue and compared against hand-computed
// addresses, data and memops. Follows KEY_BREAK_EN when it is defined.
module tb_ps2_key_writer;
  import key_pkg::*;

  localparam int TO = 300;

  logic       wrclk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_valid;
  logic [7:0] key_code;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  logic [42:0] stq[$];
  logic [7:0]  wp;
  int          kv0, fe0;
  logic [10:0] fr;

  ps2_key_writer_if mem();

  ps2_key_writer #(.TIMEOUT_CYCLES(TO)) dut (
    .wrclk     (wrclk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .mem       (mem),
    .key_valid (key_valid),
    .key_code  (key_code),
    .frame_err (frame_err)
  );

  always #5 wrclk = ~wrclk;

  always @(negedge wrclk) begin
    if (mem.we) stq.push_back({mem.memop, mem.waddr, mem.datain});
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge wrclk);
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic badpar);
    return {1'b1, (~^b) ^ badpar, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = f[i];
      cyc(4);
      ps2_clk = 1'b0;
      cyc(4);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic badpar);
    ps2_bits(mkframe(b, badpar), 0, 10);
    cyc(20);
  endtask

  task automatic expect_store(input string tag, input logic [7:0] addr,
                              input logic [31:0] data, input logic [2:0] op);
    logic [42:0] e;
    int t;
    t = 0;
    while (stq.size() == 0 && t < 100) begin
      cyc(1);
      t++;
    end
    chk({tag, "_present"}, (stq.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (stq.size() != 0) begin
      e = stq.pop_front();
      chk({tag, "_addr"},  {24'b0, e[39:32]}, {24'b0, addr});
      chk({tag, "_data"},  e[31:0], data);
      chk({tag, "_memop"}, {29'b0, e[42:40]}, {29'b0, op});
    end
  endtask

  task automatic expect_none(input string tag);
    cyc(5);
    chk(tag, stq.size(), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    @(negedge wrclk);
    chk("rst_we",     {31'b0, mem.we}, 32'd0);
    chk("rst_memop",  {29'b0, mem.memop}, 32'd2);
    chk("rst_waddr",  {24'b0, mem.waddr}, 32'd0);
    chk("rst_datain", mem.datain, 32'd0);
    chk("rst_kv",     {31'b0, key_valid}, 32'd0);
    chk("rst_kc",     {24'b0, key_code}, 32'd0);
    chk("rst_fe",     {31'b0, frame_err}, 32'd0);
    rst = 1'b0;
    cyc(10);
    expect_store("init", 8'h00, 32'h10, MEMOP_SW);
    expect_none("init_idle");
    wp = 8'h10;

    // Single make code
    kv0 = kv_cnt;
    send(8'h1C, 1'b0);
    expect_store("mk_byte", 8'h10, 32'h1C, MEMOP_SB);
    expect_store("mk_ptr",  8'h00, 32'h11, MEMOP_SW);
    chk("mk_kv", kv_cnt - kv0, 32'd1);
    @(negedge wrclk);
    chk("mk_kc", {24'b0, key_code}, 32'h1C);
    wp = 8'h11;

    // Break sequence F0 1C
    kv0 = kv_cnt;
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
`ifdef KEY_BREAK_EN
    expect_store("brk_f0",   8'h11, 32'hF0, MEMOP_SB);
    expect_store("brk_p1",   8'h00, 32'h12, MEMOP_SW);
    expect_store("brk_1c",   8'h12, 32'h1C, MEMOP_SB);
    expect_store("brk_p2",   8'h00, 32'h13, MEMOP_SW);
    chk("brk_kv", kv_cnt - kv0, 32'd2);
    wp = 8'h13;
`else
    expect_none("brk_none");
    chk("brk_kv", kv_cnt - kv0, 32'd0);
`endif

    // Extended prefix is dropped, following key stored
    kv0 = kv_cnt;
    send(8'hE0, 1'b0);
    send(8'h33, 1'b0);
    expect_store("ext_byte", wp, 32'h33, MEMOP_SB);
    expect_store("ext_ptr",  8'h00, {24'b0, wp + 8'd1}, MEMOP_SW);
    chk("ext_kv", kv_cnt - kv0, 32'd1);
    wp = wp + 8'd1;

    // Parity error
    fe0 = fe_cnt;
    kv0 = kv_cnt;
    send(8'h1C, 1'b1);
    chk("par_fe", fe_cnt - fe0, 32'd1);
    chk("par_kv", kv_cnt - kv0, 32'd0);
    expect_none("par_none");

    // Timeout after 5 bits, then a good frame
    fe0 = fe_cnt;
    ps2_bits(mkframe(8'h55, 1'b0), 0, 4);
    cyc(TO + 50);
    chk("to_fe", fe_cnt - fe0, 32'd1);
    expect_none("to_none");
    send(8'h4B, 1'b0);
    expect_store("to_byte", wp, 32'h4B, MEMOP_SB);
    expect_store("to_ptr",  8'h00, {24'b0, wp + 8'd1}, MEMOP_SW);
    wp = wp + 8'd1;

    // Reset in the middle of a frame
    fr = mkframe(8'h66, 1'b0);
    ps2_bits(fr, 0, 5);
    rst = 1'b1;
    cyc(3);
    @(negedge wrclk);
    chk("mrst_kc", {24'b0, key_code}, 32'd0);
    rst = 1'b0;
    cyc(10);
    expect_store("mrst_init", 8'h00, 32'h10, MEMOP_SW);
    ps2_bits(fr, 6, 10);
    cyc(TO + 50);
    expect_none("mrst_none");
    wp = 8'h10;

    // Wrap-around: 240 codes fill 10..FF
    for (int i = 0; i < 240; i++) begin
      send(8'((i % 112) + 1), 1'b0);
      expect_store("wrap_byte", wp, {24'b0, 8'((i % 112) + 1)}, MEMOP_SB);
      wp = (wp == 8'hFF) ? 8'h10 : wp + 8'd1;
      expect_store("wrap_ptr", 8'h00, {24'b0, wp}, MEMOP_SW);
    end
    chk("wrap_ptr_final", {24'b0, wp}, 32'h10);
    send(8'h5A, 1'b0);
    expect_store("wrap_next", 8'h10, 32'h5A, MEMOP_SB);
    expect_store("wrap_nptr", 8'h00, 32'h11, MEMOP_SW);
    expect_none("end_none");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
